mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage controller for a 5-stage pipeline. Turns a load/store held in
//   EX/MEM into a single registered request to a variable-latency memory,
//   freezes the upstream pipeline while the access is outstanding, and
//   resolves taken branches (pc_src / flush) when the stage is not stalled.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   -> a WAIT-cycle counter aborts an access after TIMEOUT_CYCLES
//                cycles without mem_ack and raises the sticky mem_error.
//   Undefined -> WAIT persists until mem_ack; mem_error is tied to 0.
//
// Ports
//   CLOCK, RESET                 rising-edge clock, async active-high reset
//   valid_in, isBranch_in,       EX/MEM control flags
//   alu_zero_in, memRead_in,
//   memwrite_in
//   alu_result_in                access address
//   write_data_mem_in            store data
//   shifted_PC_in                branch target
//   mem_ack, mem_rdata           memory completion and load data
//   mem_req, mem_we, mem_addr,   registered memory request
//   mem_wdata
//   stall, flush, pc_src         pipeline control (combinational)
//   branch_target                next PC on a taken branch
//   load_data, load_valid        captured load result, one-cycle valid
//   stall_count                  saturating count of stalled cycles
//   mem_error                    sticky timeout flag
//   fsm_state                    current controller state, for observation
//
// Handshake: mem_req rises on the edge that leaves IDLE and, together with
// mem_we/mem_addr/mem_wdata, holds steady until the edge on which mem_ack=1
// is sampled in WAIT. mem_ack seen in any other state has no effect.
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             valid_in,
  input  logic             isBranch_in,
  input  logic             alu_zero_in,
  input  logic             memRead_in,
  input  logic             memwrite_in,
  input  logic [63:0]      alu_result_in,
  input  logic [63:0]      write_data_mem_in,
  input  logic [63:0]      shifted_PC_in,
  input  logic             mem_ack,
  input  logic [63:0]      mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  output logic             stall,
  output logic             flush,
  output logic             pc_src,
  output logic [63:0]      branch_target,
  output logic [63:0]      load_data,
  output logic             load_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_error,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   access;
  logic   timeout;

  assign access    = valid_in & (memRead_in | memwrite_in);
  assign fsm_state = state;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_cnt;

  // wait_cnt holds the index of the current WAIT cycle (0-based), so the
  // abort fires on the edge that ends WAIT cycle number TIMEOUT_CYCLES.
  // An ack in that same cycle still wins.
  assign timeout = (state == WAIT) && !mem_ack &&
                   (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      if (state == IDLE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)
        mem_error <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
`endif

  // Next state and stall
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack || timeout)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A branch only redirects once the stage is free to advance.
  assign pc_src        = valid_in & isBranch_in & alu_zero_in & ~stall;
  assign flush         = pc_src;
  assign branch_target = shifted_PC_in;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      stall_count <= '0;
    end else begin
      state      <= state_nxt;
      load_valid <= 1'b0;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite_in;   // read+write together counts as a store
            mem_addr  <= alu_result_in;
            mem_wdata <= write_data_mem_in;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              load_data  <= mem_rdata;
              load_valid <= 1'b1;
            end
          end else if (timeout) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              load_data  <= '0;
              load_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Self-checking bench for mem_stage_ctrl. Each memory access is described
//   as a transaction (kind, address, data, ack delay, read data); the bench
//   derives the expected per-cycle timeline from that description: one IDLE
//   decode cycle, a run of WAIT cycles ending with the ack (or the timeout),
//   and one response cycle.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int CNT_W = 6;
  localparam int TO    = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             valid_in, isBranch_in, alu_zero_in, memRead_in, memwrite_in;
  logic [63:0]      alu_result_in, write_data_mem_in, shifted_PC_in;
  logic             mem_ack;
  logic [63:0]      mem_rdata;
  logic             mem_req, mem_we, stall, flush, pc_src, load_valid, mem_error;
  logic [63:0]      mem_addr, mem_wdata, branch_target, load_data;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       fsm_state;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .CLOCK(clk), .RESET(rst),
    .valid_in(valid_in), .isBranch_in(isBranch_in), .alu_zero_in(alu_zero_in),
    .memRead_in(memRead_in), .memwrite_in(memwrite_in),
    .alu_result_in(alu_result_in), .write_data_mem_in(write_data_mem_in),
    .shifted_PC_in(shifted_PC_in), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .flush(flush), .pc_src(pc_src), .branch_target(branch_target),
    .load_data(load_data), .load_valid(load_valid), .stall_count(stall_count),
    .mem_error(mem_error), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;
  logic        exp_err = 1'b0;
  logic [63:0] exp_ld  = '0;
  logic [63:0] exp_q[$];   // load results expected, in issue order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic bump_cnt();
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
  endtask

  // One non-access cycle: branch resolution, nothing in flight.
  task automatic drive_idle(input bit v, input bit br, input bit z, input logic [63:0] pc);
    @(posedge clk); #1;
    valid_in    = v;
    isBranch_in = br;
    alu_zero_in = z;
    memRead_in  = v ? 1'b0 : 1'($urandom);
    memwrite_in = v ? 1'b0 : 1'($urandom);
    shifted_PC_in = pc;
    mem_ack     = 1'($urandom);
    mem_rdata   = rnd64();
    #4;
    check("idle_stall", stall, 0);
    check("idle_pc_src", pc_src, v & br & z);
    check("idle_flush", flush, v & br & z);
    check("idle_target", branch_target, pc);
    check("idle_req", mem_req, 0);
    check("idle_lv", load_valid, 0);
    check("idle_ld", load_data, exp_ld);
    check("idle_cnt", stall_count, exp_cnt);
    check("idle_err", mem_error, exp_err);
  endtask

  // One complete access. d = WAIT cycles before the one carrying the ack.
  task automatic do_access(input bit rd, input bit wr, input logic [63:0] addr,
                           input logic [63:0] wd, input int d, input logic [63:0] rdat);
    bit is_load = rd & ~wr;
    bit to      = TIMEOUT_ON && (d >= TO);
    int wlen    = to ? TO : d + 1;
    int total   = wlen + 2;
    bit e_stall, e_req, e_br;
    if (is_load) exp_q.push_back(to ? 64'd0 : rdat);
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      valid_in          = 1'b1;
      memRead_in        = rd;
      memwrite_in       = wr;
      alu_result_in     = addr;
      write_data_mem_in = wd;
      isBranch_in       = 1'($urandom);
      alu_zero_in       = 1'($urandom);
      shifted_PC_in     = rnd64();
      mem_rdata         = rnd64();
      // acks outside WAIT must be ignored, so throw some in
      mem_ack = (k == 0 || k == total - 1) ? 1'($urandom) : 1'b0;
      if (!to && k == wlen) begin
        mem_ack   = 1'b1;
        mem_rdata = rdat;
      end
      #4;
      e_stall = (k < total - 1);
      e_req   = (k >= 1) && (k <= wlen);
      e_br    = isBranch_in & alu_zero_in & ~e_stall;
      check("acc_stall", stall, e_stall);
      check("acc_req", mem_req, e_req);
      check("acc_pc_src", pc_src, e_br);
      check("acc_flush", flush, e_br);
      check("acc_target", branch_target, shifted_PC_in);
      check("acc_cnt", stall_count, exp_cnt);
      check("acc_err", mem_error, exp_err);
      if (e_req) begin
        check("acc_addr", mem_addr, addr);
        check("acc_wdata", mem_wdata, wd);
        check("acc_we", mem_we, wr);
      end
      if (k == total - 1 && is_load) exp_ld = exp_q.pop_front();
      check("acc_lv", load_valid, (k == total - 1) && is_load);
      check("acc_ld", load_data, exp_ld);
      if (e_stall) bump_cnt();
      if (to && k == wlen) exp_err = 1'b1;
    end
  endtask

  task automatic reset_in_wait();
    // IDLE decode, WAIT 1, then reset in the middle of WAIT 2
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; memRead_in = 1'b1; memwrite_in = 1'b0;
      alu_result_in = rnd64(); mem_ack = 1'b0;
    end
    #2;
    rst = 1'b1;
    valid_in = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_cnt", stall_count, 0);
    check("rst_lv", load_valid, 0);
    check("rst_addr", mem_addr, 0);
    #1;
    rst = 1'b0;
    exp_cnt = 0; exp_err = 1'b0; exp_ld = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_ack = 1'b1;
      mem_rdata = rnd64();
      #4;
      check("post_rst_req", mem_req, 0);
      check("post_rst_stall", stall, 0);
      check("post_rst_lv", load_valid, 0);
      check("post_rst_ld", load_data, 0);
      check("post_rst_cnt", stall_count, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 0; isBranch_in = 0; alu_zero_in = 0; memRead_in = 0; memwrite_in = 0;
    alu_result_in = '0; write_data_mem_in = '0; shifted_PC_in = '0;
    mem_ack = 0; mem_rdata = '0;
    #12;
    check("reset_req", mem_req, 0);
    check("reset_we", mem_we, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    check("reset_ld", load_data, 0);
    check("reset_lv", load_valid, 0);
    check("reset_cnt", stall_count, 0);
    check("reset_err", mem_error, 0);
    check("reset_stall", stall, 0);
    rst = 1'b0;

    // load at 0x100, ack in first WAIT cycle
    do_access(1'b1, 1'b0, 64'h100, rnd64(), 0, 64'hDEAD);
    drive_idle(1'b0, 1'b0, 1'b0, 64'h0);
    check("load_stall_count", stall_count, 2);

    // store 0x55 at 0x200, ack in third WAIT cycle
    do_access(1'b0, 1'b1, 64'h200, 64'h55, 2, rnd64());
    drive_idle(1'b0, 1'b0, 1'b0, 64'h0);

    // branch resolution with no access
    drive_idle(1'b1, 1'b1, 1'b1, 64'h40);
    drive_idle(1'b1, 1'b1, 1'b0, 64'h40);
    drive_idle(1'b0, 1'b1, 1'b1, 64'h40);

    // read and write together behave as a store
    do_access(1'b1, 1'b1, rnd64(), rnd64(), 1, rnd64());

    reset_in_wait();

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: do_access(1'b1, 1'b0, rnd64(), rnd64(), $urandom_range(0, 6), rnd64());
        1: do_access(1'b0, 1'b1, rnd64(), rnd64(), $urandom_range(0, 6), rnd64());
        2: do_access(1'b1, 1'b1, rnd64(), rnd64(), $urandom_range(0, 6), rnd64());
        default: drive_idle(1'($urandom), 1'($urandom), 1'($urandom), rnd64());
      endcase
    end

    // long wait: stall_count saturates (timeout aborts it when enabled)
    do_access(1'b1, 1'b0, rnd64(), rnd64(), 70, rnd64());
    drive_idle(1'b0, 1'b0, 1'b0, 64'h0);
    do_access(1'b1, 1'b0, rnd64(), rnd64(), 0, rnd64());
    drive_idle(1'b1, 1'b1, 1'b1, rnd64());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
